// File: rtl/luma_invert_stage.sv
// Video pixel stage: measures per-frame mean luma, decides light/dark with hysteresis,
// and inverts RGB on light frames while forwarding sync/DE with a fixed 3-cycle latency.
module luma_invert_stage #(
  parameter int unsigned THR_HI  = 128,
  parameter int unsigned THR_LO  = 112,
  parameter int unsigned MIN_PIX = 1024,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned CNT_W   = 22
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  mode_i,
  input  logic        hs_i,
  input  logic        vs_i,
  input  logic        de_i,
  input  logic [23:0] data_i,
  output logic        hs_o,
  output logic        vs_o,
  output logic        de_o,
  output logic [23:0] data_o,
  output logic        is_light_o,
  output logic        frame_done_o
);

  localparam logic [63:0] ACC_MAX = (64'd1 << ACC_W) - 64'd1;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ACCUM   = 2'd1,
    DECIDE  = 2'd2,
    APPLY   = 2'd3
  } state_t;

  state_t state;

  logic             hs1, vs1, de1;
  logic [23:0]      data1;
  logic [7:0]       gray1;
  logic             hs2, vs2, de2;
  logic [23:0]      data2;
  logic [ACC_W-1:0] acc, acc_s, hi, lo;
  logic [CNT_W-1:0] cnt, cnt_s;
  logic             light;
  logic             vs_pend;

  logic [15:0]      gray_sum_c;
  logic [ACC_W:0]   acc_sum_c;
  logic [ACC_W-1:0] acc_inc_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic [63:0]      prod_hi_c, prod_lo_c;
  logic             vs_edge_c, acc_en_c, inv_c;

  // Luma, saturating stats increments, threshold products and the invert select.
  always_comb begin
    gray_sum_c = 16'd77 * 16'(data_i[23:16]) + 16'd150 * 16'(data_i[15:8])
               + 16'd29 * 16'(data_i[7:0]);
    acc_sum_c  = {1'b0, acc} + (ACC_W+1)'(gray1);
    acc_inc_c  = acc_sum_c[ACC_W] ? '1 : acc_sum_c[ACC_W-1:0];
    cnt_inc_c  = (&cnt) ? cnt : cnt + CNT_W'(1);
    prod_hi_c  = 64'(cnt_s) * 64'(THR_HI);
    prod_lo_c  = 64'(cnt_s) * 64'(THR_LO);
    vs_edge_c  = vs1 & ~vs2;
    acc_en_c   = de1 & ~vs1 & (state != WAIT_VS);
    inv_c      = (mode_i == 2'd2) || ((mode_i == 2'd1) && light);
  end

  assign is_light_o = light;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs1          <= 1'b0;
      vs1          <= 1'b0;
      de1          <= 1'b0;
      data1        <= '0;
      gray1        <= '0;
      hs2          <= 1'b0;
      vs2          <= 1'b0;
      de2          <= 1'b0;
      data2        <= '0;
      hs_o         <= 1'b0;
      vs_o         <= 1'b0;
      de_o         <= 1'b0;
      data_o       <= '0;
      frame_done_o <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      acc_s        <= '0;
      cnt_s        <= '0;
      hi           <= '0;
      lo           <= '0;
      light        <= 1'b0;
      vs_pend      <= 1'b0;
      state        <= WAIT_VS;
    end else begin
      hs1          <= hs_i;
      vs1          <= vs_i;
      de1          <= de_i;
      data1        <= data_i;
      gray1        <= gray_sum_c[15:8];
      hs2          <= hs1;
      vs2          <= vs1;
      de2          <= de1;
      data2        <= data1;
      hs_o         <= hs2;
      vs_o         <= vs2;
      de_o         <= de2;
      data_o       <= inv_c ? ~data2 : data2;
      frame_done_o <= 1'b0;

      if (acc_en_c) begin
        acc <= acc_inc_c;
        cnt <= cnt_inc_c;
      end

      // Stats FSM; a vs edge seen during DECIDE/APPLY is replayed on the return to ACCUM.
      case (state)
        WAIT_VS: begin
          if (vs_edge_c) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (vs_edge_c || vs_pend) begin
            acc_s   <= acc;
            cnt_s   <= cnt;
            acc     <= '0;
            cnt     <= '0;
            vs_pend <= 1'b0;
            state   <= DECIDE;
          end
        end
        DECIDE: begin
          hi    <= (prod_hi_c > ACC_MAX) ? '1 : ACC_W'(prod_hi_c);
          lo    <= (prod_lo_c > ACC_MAX) ? '1 : ACC_W'(prod_lo_c);
          if (vs_edge_c) vs_pend <= 1'b1;
          state <= APPLY;
        end
        APPLY: begin
          frame_done_o <= 1'b1;
          if (cnt_s >= CNT_W'(MIN_PIX)) begin
            if (!light && (acc_s >= hi)) light <= 1'b1;
            else if (light && (acc_s < lo)) light <= 1'b0;
          end
          if (vs_edge_c) vs_pend <= 1'b1;
          state <= ACCUM;
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

endmodule

// File: tb/tb_luma_invert_stage.sv
// Self-checking bench for luma_invert_stage: table of frames with expected decisions,
// a frame-level luma/hysteresis model, and a random 3-cycle latency check.
module tb_luma_invert_stage;

  localparam int unsigned THR_HI  = 128;
  localparam int unsigned THR_LO  = 112;
  localparam int unsigned MIN_PIX = 1024;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  mode_i = 2'd0;
  logic        hs_i = 1'b0, vs_i = 1'b0, de_i = 1'b0;
  logic [23:0] data_i = '0;
  logic        hs_o, vs_o, de_o, is_light_o, frame_done_o;
  logic [23:0] data_o;

  always #5 clk = ~clk;

  luma_invert_stage dut (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .hs_i(hs_i), .vs_i(vs_i),
    .de_i(de_i), .data_i(data_i), .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o),
    .data_o(data_o), .is_light_o(is_light_o), .frame_done_o(frame_done_o)
  );

  typedef struct {
    logic        hs, vs, de;
    logic [23:0] data;
    logic [1:0]  mode;
  } smp_t;

  typedef struct {
    int          w, h;
    logic [1:0]  md;
    logic [23:0] col;
    int          rst_line, sw_line;
    logic [1:0]  sw_md;
    logic        light;
    int          done;
  } vec_t;

  smp_t    hist[3];
  vec_t    tv[14];
  int      checks = 0, passed = 0;
  int      fd_seen = 0, bad_px = 0, skip = 100;
  bit      cmp_all = 1'b0;
  bit      exp_light = 1'b0, armed = 1'b0, exp_done = 1'b0;
  longint  m_sum = 0;
  int      m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int gray_of(input logic [23:0] c);
    return (77 * int'(c[23:16]) + 150 * int'(c[15:8]) + 29 * int'(c[7:0])) / 256;
  endfunction

  // One clock: record the inputs the DUT samples, then compare outputs to the model.
  task automatic cyc();
    logic [23:0] exp_d;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = '{hs_i, vs_i, de_i, data_i, mode_i};
    @(posedge clk);
    #1;
    if (frame_done_o) fd_seen++;
    if (skip > 0) skip--;
    else begin
      exp_d = ((hist[0].mode == 2'd2) || (hist[0].mode == 2'd1 && exp_light))
              ? ~hist[2].data : hist[2].data;
      if ({hs_o, vs_o, de_o} !== {hist[2].hs, hist[2].vs, hist[2].de}) bad_px++;
      else if ((de_o || cmp_all) && data_o !== exp_d) bad_px++;
    end
  endtask

  task automatic frame(input vec_t v);
    real mean;
    exp_done = armed;
    if (armed && m_cnt >= int'(MIN_PIX)) begin
      mean = real'(m_sum) / real'(m_cnt);
      if (!exp_light && mean >= real'(THR_HI)) exp_light = 1'b1;
      else if (exp_light && mean < real'(THR_LO)) exp_light = 1'b0;
    end
    armed = 1'b1; m_sum = 0; m_cnt = 0; fd_seen = 0; bad_px = 0;
    mode_i = v.md;
    vs_i = 1'b1; hs_i = 1'b0; de_i = 1'b0; data_i = 24'($urandom);
    repeat (4) cyc();
    vs_i = 1'b0;
    repeat (8) cyc();
    for (int l = 0; l < v.h; l++) begin
      if (l == v.sw_line) mode_i = v.sw_md;
      if (l == v.rst_line) begin
        rst_i = 1'b1; de_i = 1'b0; skip = 3;
        exp_light = 1'b0; armed = 1'b0; m_sum = 0; m_cnt = 0;
        cyc();
        check("mid_reset_outs", 32'({hs_o, vs_o, de_o, data_o, is_light_o, frame_done_o}), 32'd0);
        rst_i = 1'b0;
      end
      hs_i = 1'b0;
      for (int x = 0; x < v.w; x++) begin
        de_i = 1'b1; data_i = v.col;
        if (armed) begin m_sum += gray_of(v.col); m_cnt++; end
        cyc();
      end
      de_i = 1'b0;
      for (int b = 0; b < 8; b++) begin
        hs_i = (b < 3); data_i = 24'($urandom);
        cyc();
      end
    end
  endtask

  initial begin
    tv[0]  = '{64, 32, 2'd1, 24'hFFFFFF, -1, -1, 2'd0, 1'b0, 0};
    tv[1]  = '{64, 32, 2'd1, 24'hFFFFFF, -1, -1, 2'd0, 1'b1, 1};
    tv[2]  = '{64, 32, 2'd1, 24'hFFFFFF, -1, -1, 2'd0, 1'b1, 1};
    tv[3]  = '{32, 32, 2'd1, 24'h787878, -1, -1, 2'd0, 1'b1, 1};
    tv[4]  = '{32, 32, 2'd1, 24'h646464, -1, -1, 2'd0, 1'b1, 1};
    tv[5]  = '{32, 32, 2'd1, 24'h787878, -1, -1, 2'd0, 1'b0, 1};
    tv[6]  = '{32, 32, 2'd1, 24'h808080, -1, -1, 2'd0, 1'b0, 1};
    tv[7]  = '{16, 16, 2'd1, 24'h000000, -1, -1, 2'd0, 1'b1, 1};
    tv[8]  = '{32, 32, 2'd2, 24'h000000, -1, -1, 2'd0, 1'b1, 1};
    tv[9]  = '{32, 32, 2'd2, 24'h000000, -1, 16, 2'd0, 1'b0, 1};
    tv[10] = '{32, 32, 2'd1, 24'hFFFFFF, -1, -1, 2'd0, 1'b0, 1};
    tv[11] = '{32, 32, 2'd1, 24'hFFFFFF, 10, -1, 2'd0, 1'b0, 1};
    tv[12] = '{32, 32, 2'd1, 24'hFFFFFF, -1, -1, 2'd0, 1'b0, 0};
    tv[13] = '{32, 32, 2'd1, 24'hFFFFFF, -1, -1, 2'd0, 1'b1, 1};
    for (int i = 0; i < 3; i++) hist[i] = '{1'b0, 1'b0, 1'b0, 24'd0, 2'd0};

    // Reset with busy inputs: every output must read zero.
    mode_i = 2'd2;
    for (int i = 0; i < 4; i++) begin
      hs_i = 1'($urandom); vs_i = 1'($urandom); de_i = 1'b1; data_i = 24'($urandom);
      cyc();
    end
    check("reset_outs", 32'({hs_o, vs_o, de_o, data_o, is_light_o, frame_done_o}), 32'd0);
    rst_i = 1'b0; skip = 2;
    hs_i = 1'b0; vs_i = 1'b0; de_i = 1'b0; data_i = '0;

    for (int i = 0; i < 14; i++) begin
      frame(tv[i]);
      check($sformatf("tbl_light[%0d]", i), 32'(is_light_o), 32'(tv[i].light));
      check($sformatf("tbl_done[%0d]", i), 32'(fd_seen), 32'(tv[i].done));
      check($sformatf("model_light[%0d]", i), 32'(is_light_o), 32'(exp_light));
      check($sformatf("model_done[%0d]", i), 32'(fd_seen), 32'(exp_done));
      check($sformatf("pixels[%0d]", i), 32'(bad_px), 32'd0);
    end

    // Random sync/data in pass-through modes: outputs are the inputs 3 cycles late.
    cmp_all = 1'b1; bad_px = 0;
    for (int i = 0; i < 400; i++) begin
      hs_i = 1'($urandom); vs_i = 1'($urandom); de_i = 1'($urandom);
      data_i = 24'($urandom); mode_i = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
      cyc();
    end
    check("latency_random", 32'(bad_px), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/luma_invert_stage.md
Name: luma_invert_stage

Overview:
- Pixel-processing stage between the registered HDMI-in capture (hs/vs/de/24-bit RGB) and the HDMI-out output registers.
- Measures the average luma of each frame and decides light/dark with hysteresis.
- Applies the decision to the following frame: in a light frame, every RGB channel is inverted (255 - c).
- Forwards sync and DE with fixed latency, so output timing equals input timing delayed.

Parameters:
- THR_HI, 128: mean-gray threshold; a dark decision switches to light when mean >= THR_HI.
- THR_LO, 112: mean-gray threshold; a light decision switches to dark when mean < THR_LO. Must be <= THR_HI.
- MIN_PIX, 1024: frames with fewer DE pixels are ignored (decision held).
- ACC_W, 32: accumulator width; saturating.
- CNT_W, 22: pixel counter width; saturating.

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  synchronous reset, active-high
- mode_i  in  2  0 = bypass, 1 = auto, 2 = force invert, 3 = bypass
- hs_i  in  1  hsync
- vs_i  in  1  vsync
- de_i  in  1  data enable
- data_i  in  24  RGB, {R[23:16], G[15:8], B[7:0]}
- hs_o  out  1  hsync delayed 3 cycles
- vs_o  out  1  vsync delayed 3 cycles
- de_o  out  1  DE delayed 3 cycles
- data_o  out  24  processed RGB
- is_light_o  out  1  current decision
- frame_done_o  out  1  one-cycle pulse when a decision is evaluated

Behaviour:
- Reset: all outputs 0. Internal state: pipeline cleared, acc = 0, cnt = 0, decision = dark, FSM = WAIT_VS. Reset mid-frame discards the partial frame.
- Pipeline, fixed latency 3 for hs/vs/de/data in every mode:
  - S1 registers the inputs and computes gray = (77R + 150G + 29B) >> 8 (8 bits, max 255).
  - S2 accumulates the stats.
  - S3 selects data and registers the outputs.
- Invert enable for data at S3:
  - mode 1: the decision register value at the time the pixel is in S3.
  - mode 2: always.
  - mode 0 or 3: never.
  - Inverted data = {255-R, 255-G, 255-B}. Non-DE cycles are also passed through the mux; the sink ignores data when de_o = 0.
- vs edge: the rising edge of the S1-registered vs (vs_q & ~vs_qq).
- FSM WAIT_VS (after reset):
  - No accumulation.
  - On vs edge: clear acc/cnt, go to ACCUM.
  - No frame_done_o pulse.
- FSM ACCUM:
  - Each cycle with S1 de = 1 and vs = 0: acc += gray, cnt += 1, both saturating at all-ones.
  - de while vs = 1 is not counted.
  - On vs edge: snapshot acc/cnt into acc_s/cnt_s, clear acc/cnt in the same cycle, go to DECIDE.
- FSM DECIDE (1 cycle):
  - Register products hi = cnt_s * THR_HI and lo = cnt_s * THR_LO (ACC_W bits, saturating). Go to APPLY.
- FSM APPLY (1 cycle): pulse frame_done_o = 1, return to ACCUM, and update the decision:
  - If cnt_s < MIN_PIX: hold the decision.
  - Else if dark and acc_s >= hi: set light.
  - Else if light and acc_s < lo: set dark.
  - Otherwise hold.
- Decision timing:
  - The decision updates on the clock edge ending APPLY.
  - is_light_o = decision register.
  - It affects the next frame's pixels, since sync blanking lasts far longer than 3 cycles.
- A vs edge arriving during DECIDE/APPLY (degenerate) is still counted as a frame boundary: the pending evaluation completes, then the new frame's snapshot is taken on the return to ACCUM. Accumulation continues through DECIDE/APPLY.
- Stats are accumulated in every mode. The decision in modes 0/2 still updates; it only gates data in mode 1.
- mode_i change takes effect on the next S3 cycle; no glitch on sync outputs.

Test Plan:
- Reset, then 3 frames of 64x32 (2048 px) all 0xFFFFFF, mode 1:
  - frame_done_o pulses after the 2nd and 3rd vs edges; no pulse after the 1st.
  - is_light_o = 1 after the 2nd.
  - Frame 3 data_o = 0x000000 wherever de_o = 1.
- Latency: random hs/vs/de/data, mode 0 -> outputs equal inputs delayed exactly 3 cycles, bit-exact.
- Hysteresis:
  - Light state, frame of gray 120 (0x787878) -> stays light.
  - Frame of gray 100 -> dark.
  - Frame of gray 120 -> stays dark.
  - Frame of gray 128 -> light.
- Short frame: light state, 16x16 all-black frame (256 < MIN_PIX) -> frame_done_o pulses, is_light_o stays 1.
- Mode 2 with all-black input -> data_o = 0xFFFFFF on DE. Switch to mode 0 mid-frame -> pass-through from the 3rd cycle after.
- Assert rst_i for 1 cycle mid-frame in the light state:
  - All outputs 0 the next cycle; is_light_o = 0.
  - The next vs edge produces no frame_done_o; the following vs edge evaluates normally.
